// File: rtl/GEMM_pkg.sv
// Shared GEMM datapath types and default configuration.
package GEMM_pkg;

    localparam int unsigned GEMM_SA_SIZE    = 8;
    localparam int unsigned GEMM_ELEM_W     = 8;
    localparam int unsigned GEMM_FIFO_DEPTH = 8;

    // One result element and one full array-wide result vector.
    typedef logic [GEMM_ELEM_W-1:0]    gemm_elem_t;
    typedef gemm_elem_t [GEMM_SA_SIZE-1:0] gemm_vec_t;

endpackage : GEMM_pkg

// File: rtl/gemm_vector_fifo.sv
// Vector FIFO with a registered head so the read payload is a flop output.
module gemm_vector_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_valid,
    output logic              o_wr_ready_c,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_head;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic              r_full;

    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_ptr_n;
    logic [PTR_W-1:0]  w_rd_ptr_n;
    logic [CNT_W-1:0]  w_count_n;
    logic [DATA_W-1:0] w_head_n;

    assign w_pop        = r_valid && i_rd_ready;
    assign o_wr_ready_c = !r_full || w_pop;
    assign w_push       = i_wr_valid && o_wr_ready_c;

    // Pointer wrap (DEPTH need not be a power of two) and occupancy update.
    always_comb begin
        w_wr_ptr_n = r_wr_ptr;
        w_rd_ptr_n = r_rd_ptr;
        if (w_push) begin
            w_wr_ptr_n = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_n = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        end
        w_count_n = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Next head: the following stored entry after a pop, or the pushed word when it becomes head.
    always_comb begin
        w_head_n = r_head;
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_head_n = r_mem[w_rd_ptr_n];
            end else if (w_push) begin
                w_head_n = i_wr_data;
            end
        end else if ((r_count == '0) && w_push) begin
            w_head_n = i_wr_data;
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_valid  <= (w_count_n != '0);
            r_full   <= (w_count_n == CNT_W'(DEPTH));
        end
    end

    // Payload storage, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
        r_head <= w_head_n;
    end

    assign o_rd_valid = r_valid;
    assign o_rd_data  = r_head;

endmodule : gemm_vector_fifo

// File: rtl/gemm_output_deskew.sv
// Re-aligns skewed systolic-array output columns into whole vectors with credit flow control.
module gemm_output_deskew
    import GEMM_pkg::*;
#(
    parameter int unsigned SA_SIZE                = GEMM_SA_SIZE,
    parameter int unsigned WEIGHT_ACTIVATION_SIZE = GEMM_ELEM_W,
    parameter int unsigned FIFO_DEPTH             = GEMM_FIFO_DEPTH
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [SA_SIZE-1:0]                               col_valid,
    input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   col_data,
    output logic                                             in_ready,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   out_data,
    output logic                                             skew_error
);

    localparam int unsigned EW    = WEIGHT_ACTIVATION_SIZE;
    localparam int unsigned VEC_W = SA_SIZE * EW;
    localparam int unsigned RES_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < SA_SIZE) begin : g_bad_depth
        $error("gemm_output_deskew: FIFO_DEPTH must be >= SA_SIZE");
    end

    logic [RES_W-1:0]            r_reserved;
    logic [RES_W-1:0]            w_reserved_n;
    logic                        r_in_ready;
    logic                        r_skew_error;
    logic                        w_accept;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_skew_mis;
    logic                        w_fifo_wr_ready;
    logic [SA_SIZE-1:0]          w_acc_hist;
    logic [SA_SIZE-1:0][EW-1:0]  w_aligned;
    logic [VEC_W-1:0]            w_fifo_rd_data;

    assign w_accept = col_valid[0] && r_in_ready;
    assign w_pop    = out_valid && out_ready;

    // w_acc_hist[k] is the column-0 accept from k cycles ago; it is the expected col_valid[k].
    if (SA_SIZE > 1) begin : g_hist
        logic [SA_SIZE-2:0] r_acc_sr;

        // Shift the accept history; these are the only delay-line valid bits.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_acc_sr <= '0;
            end else begin
                r_acc_sr[0] <= w_accept;
                for (int k = 1; k < int'(SA_SIZE - 1); k++) begin
                    r_acc_sr[k] <= r_acc_sr[k-1];
                end
            end
        end

        assign w_acc_hist = {r_acc_sr, w_accept};
    end else begin : g_nohist
        assign w_acc_hist = w_accept;
    end

    // Column c waits SA_SIZE-1-c cycles so all columns of a vector line up.
    for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
        localparam int unsigned DLY = SA_SIZE - 1 - c;
        if (DLY == 0) begin : g_thru
            assign w_aligned[c] = col_data[c];
        end else begin : g_dly
            logic [EW-1:0] r_dly [DLY];

            // Data-only delay line; validity comes from the accept history.
            always_ff @(posedge clk) begin
                r_dly[0] <= col_data[c];
                for (int k = 1; k < int'(DLY); k++) begin
                    r_dly[k] <= r_dly[k-1];
                end
            end

            assign w_aligned[c] = r_dly[DLY-1];
        end
    end

    // A vector is complete once its column-0 accept has aged SA_SIZE-1 cycles.
    assign w_push = w_acc_hist[SA_SIZE-1];

    // Protocol checks: start while not ready, or any column valid out of step with column 0.
    always_comb begin
        w_skew_mis = col_valid[0] && !r_in_ready;
        for (int c = 1; c < int'(SA_SIZE); c++) begin
            if (col_valid[c] != w_acc_hist[c]) begin
                w_skew_mis = 1'b1;
            end
        end
    end

    // Reserved slots cover both buffered and in-flight vectors.
    always_comb begin
        w_reserved_n = r_reserved + RES_W'(w_accept) - RES_W'(w_pop);
    end

    // Credit counter, registered ready and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reserved   <= '0;
            r_in_ready   <= 1'b1;
            r_skew_error <= 1'b0;
        end else begin
            r_reserved   <= w_reserved_n;
            r_in_ready   <= (w_reserved_n < RES_W'(FIFO_DEPTH));
            r_skew_error <= r_skew_error | w_skew_mis;
        end
    end

    gemm_vector_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (VEC_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_wr_valid   (w_push),
        .o_wr_ready_c (w_fifo_wr_ready),
        .i_wr_data    (w_aligned),
        .o_rd_valid   (out_valid),
        .i_rd_ready   (out_ready),
        .o_rd_data    (w_fifo_rd_data)
    );

    assign out_data   = w_fifo_rd_data;
    assign in_ready   = r_in_ready;
    assign skew_error = r_skew_error;

    // The credit scheme guarantees a completed vector always has a slot.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        w_push |-> w_fifo_wr_ready);

    a_reserved_bound : assert property (@(posedge clk) disable iff (reset)
        r_reserved <= RES_W'(FIFO_DEPTH));

endmodule : gemm_output_deskew

// File: tb/tb_gemm_output_deskew.sv
// Directed bench for gemm_output_deskew at SA_SIZE=2, element width 8, FIFO depth 2.
module tb_gemm_output_deskew;

    localparam int unsigned SA = 2;
    localparam int unsigned EW = 8;
    localparam int unsigned FD = 2;

    logic                   clk;
    logic                   reset;
    logic [SA-1:0]          col_valid;
    logic [SA-1:0][EW-1:0]  col_data;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [SA-1:0][EW-1:0]  out_data;
    logic                   skew_error;

    int checks;
    int errors;

    gemm_output_deskew #(
        .SA_SIZE                (SA),
        .WEIGHT_ACTIVATION_SIZE (EW),
        .FIFO_DEPTH             (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .col_valid  (col_valid),
        .col_data   (col_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .skew_error (skew_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        col_valid = v;
        col_data  = {d1, d0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'b00, 8'h00, 8'h00);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        out_ready = 1'b1;
        #1;
        do_reset();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_skew", 32'(skew_error), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single vector {6,10}
        drive(2'b01, 8'd6, 8'd0);
        step();
        drive(2'b10, 8'd0, 8'd10);
        chk("single_t1_valid", 32'(out_valid), 32'd0);
        step();
        drive(2'b00, 8'd0, 8'd0);
        chk("single_t2_valid", 32'(out_valid), 32'd1);
        chk("single_t2_data", 32'(out_data), 32'h0A06);
        chk("single_t2_skew", 32'(skew_error), 32'd0);
        step();
        chk("single_t3_valid", 32'(out_valid), 32'd0);

        // Back-to-back {6,10} then {9,4}
        drive(2'b01, 8'd6, 8'd0);
        step();
        drive(2'b11, 8'd9, 8'd10);
        step();
        drive(2'b10, 8'd0, 8'd4);
        chk("b2b_t2_valid", 32'(out_valid), 32'd1);
        chk("b2b_t2_data", 32'(out_data), 32'h0A06);
        step();
        drive(2'b00, 8'd0, 8'd0);
        chk("b2b_t3_valid", 32'(out_valid), 32'd1);
        chk("b2b_t3_data", 32'(out_data), 32'h0409);
        step();
        chk("b2b_t4_valid", 32'(out_valid), 32'd0);
        chk("b2b_skew", 32'(skew_error), 32'd0);

        // Backpressure: two accepted, third start dropped, then ordered drain
        out_ready = 1'b0;
        drive(2'b01, 8'd6, 8'd0);
        step();
        drive(2'b11, 8'd9, 8'd10);
        chk("bp_t1_in_ready", 32'(in_ready), 32'd1);
        step();
        drive(2'b11, 8'd77, 8'd4);
        chk("bp_t2_in_ready", 32'(in_ready), 32'd0);
        chk("bp_t2_valid", 32'(out_valid), 32'd1);
        chk("bp_t2_data", 32'(out_data), 32'h0A06);
        step();
        drive(2'b00, 8'd0, 8'd0);
        chk("bp_t3_skew", 32'(skew_error), 32'd1);
        chk("bp_t3_data_hold", 32'(out_data), 32'h0A06);
        chk("bp_t3_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("bp_t4_data_hold", 32'(out_data), 32'h0A06);
        out_ready = 1'b1;
        step();
        chk("bp_t5_valid", 32'(out_valid), 32'd1);
        chk("bp_t5_data", 32'(out_data), 32'h0409);
        chk("bp_t5_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_t6_valid", 32'(out_valid), 32'd0);
        do_reset();
        chk("bp_rst_skew", 32'(skew_error), 32'd0);

        // Column 1 missing: sticky skew error, data still written as received
        drive(2'b01, 8'd6, 8'd0);
        step();
        drive(2'b00, 8'd0, 8'd55);
        step();
        drive(2'b00, 8'd0, 8'd0);
        chk("skew_t2_flag", 32'(skew_error), 32'd1);
        chk("skew_t2_valid", 32'(out_valid), 32'd1);
        chk("skew_t2_data", 32'(out_data), 32'h3706);
        for (int i = 0; i < 4; i++) step();
        chk("skew_sticky", 32'(skew_error), 32'd1);
        do_reset();
        chk("skew_rst_clear", 32'(skew_error), 32'd0);

        // Reset during an in-flight vector discards it
        drive(2'b01, 8'd6, 8'd0);
        step();
        drive(2'b10, 8'd0, 8'd10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(2'b00, 8'd0, 8'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        chk("midrst_skew", 32'(skew_error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gemm_output_deskew
